// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
// Latency: n/a (types, parameters and a width helper only).
// Backpressure: n/a; the core's stall logic imports the same defaults.
package mem_resp_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 4;

    // Width of the latency down-counter: enough to hold LATENCY-1, never zero bits.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the responder (slave).
// Ports: enable/wr/addr/data_in from master; busy/data_valid/data_out from slave.
// Backpressure: busy high means the slave ignores enable; master holds its request until busy=0.
interface data_mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;

    modport master (
        output enable, wr, addr, data_in,
        input  busy, data_valid, data_out
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output busy, data_valid, data_out
    );
endinterface

// File: rtl/mem_word_array.sv
// Single-port DEPTH x DATA_W word store; no reset, contents survive responder reset.
// Latency: write and registered read both take effect on the edge where we/re is high.
// Backpressure: none; rdata holds its value until the next re.
// Ports: clk, we, re, addr (word index), wdata, rdata.
module mem_word_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one read/write, completes it LATENCY edges later.
// Latency: busy for LATENCY cycles after accept; read data_valid pulses in the following cycle.
// Backpressure: busy=1 ignores enable (no queueing); requester holds until busy=0.
// Ports: clk, rst_n (async active-low), bus (slave modport of data_mem_responder_if).
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              data_valid_q;
    logic              rd_seen;
    logic              lat_wr;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_data;

    logic              done;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    // Address bits above the word index (and the byte bit) are dropped on purpose.
    logic unused_addr;
    assign unused_addr = ^bus.addr;

    // Completion edge: last BUSY cycle. Gated by state so a reset aborts the access.
    assign done   = (state == S_BUSY) && (cnt == '0);
    assign arr_we = done && lat_wr;
    assign arr_re = done && !lat_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            rd_seen      <= 1'b0;
            lat_wr       <= 1'b0;
            lat_idx      <= '0;
            lat_data     <= '0;
        end else begin
            data_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        lat_wr   <= bus.wr;
                        lat_idx  <= bus.addr[IDX_W:1];
                        lat_data <= bus.data_in;
                        cnt      <= CNT_W'(LATENCY - 1);
                        state    <= S_BUSY;
                        busy_q   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        if (!lat_wr) begin
                            data_valid_q <= 1'b1;
                            rd_seen      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    mem_word_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (lat_idx),
        .wdata (lat_data),
        .rdata (arr_rdata)
    );

    assign bus.busy       = busy_q;
    assign bus.data_valid = data_valid_q;
    // The array read register has no reset; until a read completes after reset, show zero.
    assign bus.data_out   = rd_seen ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        wr_s;
    logic [15:0] addr_s;
    logic [15:0] din;
    int          sel;
    int          cyc;
    int          checks;
    int          errors;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] last_rd[2];
    logic [15:0] mdl[2][DEPTH];
    bit          wrt[2][DEPTH];

    data_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    data_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    assign bus0.enable  = en && (sel == 0);
    assign bus0.wr      = wr_s;
    assign bus0.addr    = addr_s;
    assign bus0.data_in = din;
    assign bus1.enable  = en && (sel == 1);
    assign bus1.wr      = wr_s;
    assign bus1.addr    = addr_s;
    assign bus1.data_in = din;

    data_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    data_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic cur_busy();
        return (sel == 0) ? bus0.busy : bus1.busy;
    endfunction

    // Scoreboard monitor: one DUT per call, sampled at the falling edge.
    task automatic mon_one(input int k, input logic dv, input logic [15:0] dout);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (dv) begin
            if (sz == 0) begin
                check(k == 0 ? "unexpected_valid_l4" : "unexpected_valid_l1", 1, 0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check(k == 0 ? "read_data_l4" : "read_data_l1", dout, e.data);
                check(k == 0 ? "valid_cycle_l4" : "valid_cycle_l1", cyc, e.due);
                last_rd[k] = e.data;
            end
        end else if (sz > 0) begin
            e = (k == 0) ? q0[0] : q1[0];
            if (e.due < cyc) begin
                check(k == 0 ? "missed_valid_l4" : "missed_valid_l1", 0, 1);
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
        check(k == 0 ? "data_out_hold_l4" : "data_out_hold_l1", dout, last_rd[k]);
    endtask

    always @(negedge clk) begin
        mon_one(0, bus0.data_valid, bus0.data_out);
        mon_one(1, bus1.data_valid, bus1.data_out);
    end

    // Issue one request on the selected DUT starting at a falling edge.
    // mode while busy: 0 idle, 1 write 0x1234 to same addr, 2 hold request, 3 random junk.
    task automatic req(input bit w, input int a, input logic [15:0] d, input int mode,
                       output int acc);
        int   n;
        int   lat;
        int   idx;
        exp_t e;
        lat    = (sel == 0) ? 4 : 1;
        en     = 1'b1;
        wr_s   = w;
        addr_s = a[15:0];
        din    = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cur_busy() && n < 20);
        check("accept", cur_busy(), 1);
        acc = cyc;
        idx = (a / 2) % DEPTH;
        if (w) begin
            mdl[sel][idx] = d;
            wrt[sel][idx] = 1'b1;
        end else begin
            e.data = mdl[sel][idx];
            e.due  = acc + lat;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            if (cur_busy()) begin
                n++;
                case (mode)
                    1: begin
                        en   = 1'b1;
                        wr_s = 1'b1;
                        din  = 16'h1234;
                    end
                    3: begin
                        en     = 1'($urandom_range(0, 1));
                        wr_s   = 1'($urandom_range(0, 1));
                        addr_s = 16'($urandom_range(0, 65535));
                        din    = 16'($urandom_range(0, 65535));
                    end
                    default: en = (mode == 2);
                endcase
            end
        end while (cur_busy() && n < 40);
        en = 1'b0;
        check("busy_cycles", n, lat);
    endtask

    task automatic rand_phase(input int count);
        int  acc;
        int  idx;
        int  a;
        bit  w;
        for (int i = 0; i < count; i++) begin
            idx = 256 + 3 * $urandom_range(0, 15);
            w   = $urandom_range(0, 1) == 1 || !wrt[sel][idx];
            a   = (idx * 2 + $urandom_range(0, 1)) + 2 * DEPTH * $urandom_range(0, 31);
            req(w, a, 16'($urandom_range(0, 65535)), $urandom_range(0, 3), acc);
        end
    endtask

    initial begin
        int a1;
        int a2;
        checks     = 0;
        errors     = 0;
        en         = 1'b0;
        wr_s       = 1'b0;
        addr_s     = '0;
        din        = '0;
        sel        = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n      = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy_l4", bus0.busy, 0);
        check("reset_valid_l4", bus0.data_valid, 0);
        check("reset_busy_l1", bus1.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read
        req(1, 'h0010, 16'hBEEF, 0, a1);
        req(0, 'h0010, 16'h0000, 0, a1);

        // Writes presented while busy are ignored
        req(1, 'h0020, 16'h0F0F, 0, a1);
        req(0, 'h0020, 16'h0000, 1, a1);
        req(0, 'h0020, 16'h0000, 0, a1);

        // Aliasing: byte bit and wrap above DEPTH words
        req(1, 'h0003, 16'hA5A5, 3, a1);
        req(0, 'h0002, 16'h0000, 0, a1);
        req(1, 2 * DEPTH + 4, 16'h5A5A, 0, a1);
        req(0, 'h0004, 16'h0000, 0, a1);

        // Reset two cycles into a write must leave the old word
        req(1, 'h0030, 16'h1111, 0, a1);
        req(0, 'h0030, 16'h0000, 0, a1);
        en     = 1'b1;
        wr_s   = 1'b1;
        addr_s = 16'h0030;
        din    = 16'h7777;
        @(posedge clk);
        #1;
        check("mid_write_accept", bus0.busy, 1);
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        q0.delete();
        q1.delete();
        #1;
        check("rst_async_busy", bus0.busy, 0);
        check("rst_async_valid", bus0.data_valid, 0);
        check("rst_async_data", bus0.data_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req(0, 'h0030, 16'h0000, 0, a1);

        // Back-to-back reads with enable held
        req(1, 'h0040, 16'hC001, 0, a1);
        req(1, 'h0042, 16'hD00D, 0, a1);
        req(0, 'h0040, 16'h0000, 2, a1);
        req(0, 'h0042, 16'h0000, 2, a2);
        check("b2b_spacing", a2 - a1, 5);

        rand_phase(40);

        // LATENCY=1 instance
        sel = 1;
        @(negedge clk);
        req(1, 'h0010, 16'h3C3C, 0, a1);
        req(0, 'h0010, 16'h0000, 0, a1);
        req(0, 'h0010, 16'h0000, 2, a2);
        check("l1_b2b_spacing", a2 - a1, 2);
        rand_phase(15);

        repeat (8) @(negedge clk);
        check("q_l4_drained", q0.size(), 0);
        check("q_l1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder: the slave end of the processor's data-memory request interface (enable / wr / addr / data_in). It accepts one word read or write request at a time and completes it a fixed LATENCY cycles later. Reads complete with a one-cycle data_valid pulse. The pipelined processor core stalls on busy and consumes data_valid, replacing the single-cycle data memory.

## Interface
- ADDR_W, 16: byte-address width; the word index is addr[ADDR_W-1:1].
- DATA_W, 16: word width.
- DEPTH, 1024: number of words stored; power of two, at most 2^(ADDR_W-1).
- LATENCY, 4: edges from accept to completion; legal range 1..15.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  request present this cycle.
- wr  in  1  1 = write, 0 = read; qualified by enable.
- addr  in  ADDR_W  byte address; bit 0 is ignored.
- data_in  in  DATA_W  write data; qualified by enable & wr.
- busy  out  1  a request is in flight; new requests are ignored.
- data_valid  out  1  one-cycle pulse; data_out holds the completed read.
- data_out  out  DATA_W  last completed read data; held until the next read completes.

## Operation
- States: IDLE and BUSY. A down-counter cnt has width $clog2(LATENCY) bits, minimum 1.
- Accept: in IDLE, enable=1 at a rising edge E0 causes the following:
  - The block latches wr, word index, and data_in.
  - cnt <= LATENCY-1 and the state goes to BUSY.
- In BUSY with cnt≠0: cnt decrements each edge.
- In BUSY with cnt==0, the next edge (E_LATENCY) completes the request:
  - Write: the array word at the latched index gets the latched data. data_valid stays 0.
  - Read: data_out <= array[latched index] and data_valid <= 1 for exactly one cycle.
  - The state returns to IDLE.
- enable while busy=1 is ignored. Requests are not queued. The requester holds its request until it sees busy=0.
- Address wrap: word index = addr[ADDR_W-1:1] mod DEPTH. The upper bits are dropped and no error is raised.
- Latched inputs are immune to input changes after E0.
- A read completing after a write to the same word returns the new data.
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE, cnt=0, busy=0, data_valid=0, data_out=0.
  - An in-flight write is aborted: the array is not modified.
  - Array contents are not cleared by reset.

## Timing
- busy = (state==BUSY). It is registered, high for exactly LATENCY cycles, from E0 to E_LATENCY.
- data_valid is registered and high in the cycle after E_LATENCY, while busy is already 0.
- Back-to-back requests:
  - A requester that holds enable sees the next accept at E_LATENCY+1 if enable is high during the data_valid cycle.
  - Maximum throughput is one request per LATENCY+1 cycles.
- With LATENCY=1, busy is high for one cycle and data_valid follows at E1.
- Read latency from request edge to data_out valid: LATENCY edges.
- No combinational path exists from inputs to outputs.

## Structure
- Package mem_resp_pkg holds:
  - the state enum (S_IDLE, S_BUSY);
  - default localparams for ADDR_W, DATA_W, DEPTH, LATENCY, shared with the core's stall logic.
- Sub-module mem_word_array holds the storage:
  - synchronous single-port DEPTH×DATA_W array with we, addr, wdata, rdata;
  - no reset;
  - read data registered on the completion edge.
- The FSM, counter, and request latches live in data_mem_responder.

## Test plan
- Write then read: write 0xBEEF to addr 0x0010 (LATENCY=4).
  - Required: busy is high for 4 cycles and data_valid stays 0.
  - Then read 0x0010. Required: data_valid pulses exactly 4 edges after accept, with data_out=0xBEEF.
- Ignore while busy: while busy from a read of 0x0020, present a write of 0x1234 to 0x0020.
  - Required: the write has no effect and the read returns the prior contents.
  - A subsequent read of 0x0020 is unchanged.
- Address aliasing:
  - Write 0xA5A5 to addr 0x0003. Required: a read of 0x0002 returns 0xA5A5 (bit 0 ignored).
  - Write 0x5A5A to byte address 2×DEPTH+4. Required: a read of 0x0004 returns 0x5A5A.
- Reset mid-write: write 0x7777 to 0x0030, which holds 0x1111, and assert rst_n=0 two cycles after accept.
  - Required: busy, data_valid, and data_out drop to 0 immediately.
  - After release, a read of 0x0030 returns 0x1111.
- Back-to-back reads: hold enable for reads of 0x0040 and then 0x0042, which hold distinct values.
  - Required: data_valid pulses are LATENCY+1 cycles apart with the correct data each time.
  - Required: data_out holds the first value between the pulses.
- LATENCY=1 build: write then read.
  - Required: busy is high for 1 cycle per request.
  - Required: data_valid appears the cycle after the accept edge.
